tsc_capture_ctrl: RTL and testbench

Trigger/capture controller that sequences the 16x8 transient-capture ring buffer. It streams incoming samples into the buffer circularly and freezes the buffer a fixed number of samples after a trigger. It then reads the frozen window out oldest-first over a valid/ready stream. It sits between the sample source and the buffer memory, and owns every buffer write and read address.

---
 rtl/tsc_pkg.sv | 20 ++
 rtl/tsc_capture_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tsc_capture_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// tsc_pkg: shared definitions for the transient-capture controller.
//   state_e      - controller FSM states
//   DEF_*        - default sizing for the 16x8 capture ring buffer
package tsc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_POST   = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        CAPTURE = 3'd2,
        READY   = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5
    } state_e;

endpackage

// File: rtl/tsc_capture_ctrl.sv
// tsc_capture_ctrl: trigger/capture sequencer for a circular sample buffer.
// Streams samples into the buffer, freezes it POST samples after a trigger,
// then reads the frozen window out oldest-first.
//
// Ports:
//   clk, reset           - clock (rising edge), synchronous active-high reset
//   arm, abort           - start a capture / readout; return to IDLE
//   trigger              - trigger request level
//   sample_valid/_data   - incoming sample stream
//   buf_we/waddr/wdata   - registered buffer write port
//   buf_raddr/buf_rdata  - buffer read port (rdata one cycle after raddr)
//   out_valid/ready/data - readout stream
//   busy, done           - status
//
// Readout handshake: out_data is valid while out_valid is high and is held
// stable until the cycle out_ready is sampled high; that cycle completes the
// beat. At most one beat every two cycles.
module tsc_capture_ctrl
    import tsc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int POST   = DEF_POST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - POST);
    localparam logic [ADDR_W-1:0] FILL_PRE = ADDR_W'(DEPTH - POST - 1);
    localparam logic [ADDR_W-1:0] POST_L   = ADDR_W'(POST);
    localparam logic [ADDR_W-1:0] LAST_RD  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   post_q, post_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, done_q, out_valid_q;
    logic                trig_ok;
    logic [ADDR_W-1:0]   post_first;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        post_d     = post_q;
        rd_d       = rd_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        // Trigger is qualified against the history count including the
        // sample written this cycle, so the sample that completes the
        // pre-trigger history may itself be the trigger sample.
        trig_ok    = (fill_q == FILL_MAX) || (sample_valid && (fill_q == FILL_PRE));
        post_first = sample_valid ? ONE : '0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = FILL;
                    wptr_d  = '0;
                    fill_d  = '0;
                end
            end
            FILL: begin
                if (sample_valid) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = sample_data;
                    wptr_d  = wptr_q + ONE;
                    if (fill_q != FILL_MAX) fill_d = fill_q + ONE;
                end
                if (trigger && trig_ok) begin
                    post_d  = post_first;
                    state_d = (post_first == POST_L) ? READY : CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = sample_data;
                    wptr_d  = wptr_q + ONE;
                    post_d  = post_q + ONE;
                    if ((post_q + ONE) == POST_L) state_d = READY;
                end
            end
            READY: begin
                // wptr now points at the oldest entry of the frozen window.
                rptr_d = wptr_q;
                if (arm) begin
                    state_d = RD_ADDR;
                    rd_d    = '0;
                end
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (out_ready) begin
                    rptr_d  = rptr_q + ONE;
                    rd_d    = rd_q + ONE;
                    state_d = (rd_q == LAST_RD) ? IDLE : RD_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= (state_d == FILL) || (state_d == CAPTURE) ||
                           (state_d == RD_ADDR) || (state_d == RD_DATA);
            done_q      <= (state_d == READY);
            out_valid_q <= (state_d == RD_DATA);
        end
    end

    assign buf_we    = we_q;
    assign buf_waddr = waddr_q;
    assign buf_wdata = wdata_q;
    // raddr stays at rptr through RD_DATA, so buf_rdata holds under backpressure.
    assign buf_raddr = rptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? buf_rdata : '0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tsc_capture_ctrl.sv
// tb_tsc_capture_ctrl: directed bench for tsc_capture_ctrl with a behavioural
// buffer memory, a write scoreboard and a readout scoreboard.
module tb_tsc_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm, abort, trigger, sample_valid, out_ready;
    logic [7:0] sample_data;
    logic       buf_we, out_valid, busy, done;
    logic [3:0] buf_waddr, buf_raddr;
    logic [7:0] buf_wdata, buf_rdata, out_data;

    logic [7:0]  mem [16];
    bit          loaded = 1'b0;
    logic [11:0] wexp_q[$];
    logic [7:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          beats = 0;

    tsc_capture_ctrl dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // clock / buffer memory model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hC0 + 8'(i);
            loaded <= 1'b1;
        end else if (buf_we) begin
            mem[buf_waddr] <= buf_wdata;
        end
        buf_rdata <= loaded ? mem[buf_raddr] : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // write monitor
    always @(negedge clk) begin
        if (buf_we) begin
            if (wexp_q.size() == 0) begin
                check("unexpected_write", {20'h0, buf_waddr, buf_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("write", {20'h0, buf_waddr, buf_wdata}, {20'h0, wexp_q.pop_front()});
            end
        end
    end

    // readout monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("read_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic trig, input logic exp_wr, input logic [3:0] addr);
        if (exp_wr) wexp_q.push_back({addr, d});
        sample_valid = 1'b1;
        sample_data  = d;
        trigger      = trig;
        tick();
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check(name, {31'h0, got}, 32'h1);
    endtask

    task automatic wait_drain(input string name);
        bit empty = 1'b0;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1'b1;
        end
        check(name, {31'h0, empty}, 32'h1);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        sample_valid = 1'b0; sample_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_buf_we", {31'h0, buf_we}, 32'h0);
        check("rst_raddr", {28'h0, buf_raddr}, 32'h0);
        check("rst_waddr_wdata", {20'h0, buf_waddr, buf_wdata}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Pre-fill guard: trigger ignored with only 4 samples of history.
        pulse_arm();
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0, 1'b1, 4'(i));
        trigger = 1'b1;
        repeat (3) tick();
        trigger = 1'b0;
        check("guard_busy", {31'h0, busy}, 32'h1);
        check("guard_wq", wexp_q.size(), 0);
        // Still in FILL: eight more samples must not complete a capture.
        for (int i = 4; i < 12; i++) send(8'h50 + 8'(i), 1'b0, 1'b1, 4'(i));
        tick();
        check("guard_done", {31'h0, done}, 32'h0);
        check("guard_busy2", {31'h0, busy}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("guard_abort_busy", {31'h0, busy}, 32'h0);
        tick();

        // Basic capture: trigger held high, accepted on sample 0x07.
        do_reset();
        pulse_arm();
        for (int i = 0; i < 32; i++) send(8'(i), 1'b1, (i < 15), 4'(i));
        tick();
        check("basic_wq", wexp_q.size(), 0);
        check("basic_done", {31'h0, done}, 32'h1);
        check("basic_busy", {31'h0, busy}, 32'h0);
        // Address 15 still holds its preload value; window starts there.
        exp_q.push_back(8'hCF);
        for (int i = 0; i < 15; i++) exp_q.push_back(8'(i));
        beats = 0;
        out_ready = 1'b1;
        pulse_arm();
        wait_drain("basic_drain");
        check("basic_beats", beats, 16);
        check("basic_end_busy", {31'h0, busy}, 32'h0);
        check("basic_end_done", {31'h0, done}, 32'h0);
        check("basic_end_valid", {31'h0, out_valid}, 32'h0);

        // Wrap-around with backpressure: 41 pre-trigger samples, 8 post.
        out_ready = 1'b0;
        do_reset();
        pulse_arm();
        for (int i = 0; i < 41; i++) send(8'h40 + 8'(i), 1'b0, 1'b1, 4'(i % 16));
        for (int i = 41; i < 49; i++) send(8'h40 + 8'(i), 1'b1, 1'b1, 4'(i % 16));
        send(8'hEE, 1'b0, 1'b0, 4'h0);
        send(8'hEF, 1'b1, 1'b0, 4'h0);
        tick();
        check("wrap_wq", wexp_q.size(), 0);
        check("wrap_done", {31'h0, done}, 32'h1);
        for (int i = 33; i < 49; i++) exp_q.push_back(8'h40 + 8'(i));
        pulse_arm();
        wait_out_valid("wrap_first_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_data", {24'h0, out_data}, 32'h61);
            check("bp_raddr", {28'h0, buf_raddr}, 32'h1);
            tick();
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("wrap_drain");
        check("wrap_end_busy", {31'h0, busy}, 32'h0);
        out_ready = 1'b0;

        // Abort in CAPTURE together with a sample: that sample is not written.
        do_reset();
        pulse_arm();
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0, 1'b1, 4'(i));
        send(8'h88, 1'b1, 1'b1, 4'h8);
        abort = 1'b1;
        send(8'h89, 1'b0, 1'b0, 4'h9);
        abort = 1'b0;
        @(negedge clk);
        check("abort_we", {31'h0, buf_we}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_wq", wexp_q.size(), 0);
        tick();

        // Reset in the middle of RD_DATA.
        pulse_arm();
        for (int i = 0; i < 8; i++) send(8'h90 + 8'(i), 1'b0, 1'b1, 4'(i));
        for (int i = 8; i < 16; i++) send(8'h90 + 8'(i), 1'b1, 1'b1, 4'(i));
        tick();
        check("rr_done", {31'h0, done}, 32'h1);
        pulse_arm();
        wait_out_valid("rr_valid");
        check("rr_data", {24'h0, out_data}, 32'h90);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_out_valid", {31'h0, out_valid}, 32'h0);
        check("rr_busy", {31'h0, busy}, 32'h0);
        check("rr_done0", {31'h0, done}, 32'h0);
        check("rr_raddr", {28'h0, buf_raddr}, 32'h0);
        check("rr_out_data", {24'h0, out_data}, 32'h0);
        check("rr_we", {31'h0, buf_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        check("final_exp_q", exp_q.size(), 0);
        check("final_wexp_q", wexp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
